// File: rtl/ahb_arbiter.sv
// ahb_arbiter
//   Round-robin arbiter sharing one AHB address/data path between up to
//   eight masters. It grants ownership only at AHB-legal boundaries, keeps
//   the bus with a locked owner, and limits how long one master may hold
//   the bus while others wait.
//
// Ports
//   hclk       : AHB clock, all state on its rising edge
//   hreset     : synchronous active-high reset
//   hbusreq    : per-master bus request (bit i = master i)
//   hlock      : per-master lock request, only meaningful with hbusreq
//   htrans     : transfer type of the current address-phase owner
//   hready     : transfer complete from the slave side
//   hgrant     : one-hot grant, registered
//   hmaster    : index of the address-phase owner, registered
//   hmastlock  : current address phase belongs to a locked sequence
//   state_dbg  : arbiter FSM state (PARK / OWN / HANDOVER)
//
// Handshake: a master holds hbusreq high until it sees its hgrant bit and
// hready=1 on the same edge. From that edge it owns the address phase, and
// hmaster names it. hgrant and hmaster only move on edges with hready=1, so
// a transfer that is stretched by wait states never loses its owner.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_HOLD       = 16
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [2:0]             hmaster,
  output logic                   hmastlock,
  output logic [1:0]             state_dbg
);

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] DEF_IDX  = IDX_W'(DEFAULT_MASTER);
  localparam logic [7:0]       HOLD_MAX = 8'(MAX_HOLD);

  localparam logic [1:0] ST_PARK     = 2'd0;
  localparam logic [1:0] ST_OWN      = 2'd1;
  localparam logic [1:0] ST_HANDOVER = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic [7:0]       hold_cnt;
  logic             to_park;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_MASTERS-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_MASTERS; i++) v[i] = (idx == IDX_W'(i));
    return v;
  endfunction

  // Round-robin search: requesters above the pointer come first (lowest
  // index first), then those at or below it. The pointer holds the last
  // owner, so that master is searched last.
  logic             found_hi, found_lo, found;
  logic [IDX_W-1:0] win_hi, win_lo, winner;

  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hbusreq[i] && (IDX_W'(i) > ptr) && !found_hi) begin
        found_hi = 1'b1;
        win_hi   = IDX_W'(i);
      end
      if (hbusreq[i] && (IDX_W'(i) <= ptr) && !found_lo) begin
        found_lo = 1'b1;
        win_lo   = IDX_W'(i);
      end
    end
    found  = found_hi | found_lo;
    winner = found_hi ? win_hi : win_lo;
  end

  // Request and lock of the current owner and of the pending grantee.
  // A lock only counts while the same master is also requesting.
  logic owner_req, owner_lock, grant_lock, default_lock;

  always_comb begin
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    grant_lock = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hmaster == IDX_W'(i)) begin
        owner_req  = hbusreq[i];
        owner_lock = hlock[i] & hbusreq[i];
      end
      if (grant_idx == IDX_W'(i)) grant_lock = hlock[i] & hbusreq[i];
    end
    default_lock = hlock[DEFAULT_MASTER] & hbusreq[DEFAULT_MASTER];
  end

  logic others_req, hold_hit, burst_edge, rearb;

  // htrans[0]=0 covers exactly IDLE and NONSEQ; BUSY and SEQ sit inside a
  // burst and must not be split.
  assign others_req = |(hbusreq & ~onehot(hmaster));
  assign hold_hit   = (hold_cnt == HOLD_MAX);
  assign burst_edge = ~htrans[0];
  assign rearb      = (state == ST_OWN) && hready && burst_edge && !owner_lock &&
                      (!owner_req || (hold_hit && others_req));

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_PARK;
      hgrant    <= onehot(DEF_IDX);
      hmaster   <= DEF_IDX;
      hmastlock <= 1'b0;
      ptr       <= DEF_IDX;
      grant_idx <= DEF_IDX;
      hold_cnt  <= '0;
      to_park   <= 1'b0;
    end else if (hready) begin
      case (state)
        ST_PARK: begin
          if (found) begin
            if (winner == DEF_IDX) begin
              // The parked master already drives the address phase.
              state     <= ST_OWN;
              ptr       <= DEF_IDX;
              hold_cnt  <= '0;
              hmastlock <= default_lock;
            end else begin
              state     <= ST_HANDOVER;
              hgrant    <= onehot(winner);
              grant_idx <= winner;
              to_park   <= 1'b0;
            end
          end
        end
        ST_HANDOVER: begin
          hmaster  <= grant_idx;
          hold_cnt <= '0;
          if (to_park) begin
            // Parking does not move the pointer, so the last real owner
            // stays last in line.
            state     <= ST_PARK;
            hmastlock <= 1'b0;
          end else begin
            state     <= ST_OWN;
            ptr       <= grant_idx;
            hmastlock <= grant_lock;
          end
        end
        ST_OWN: begin
          hmastlock <= owner_lock;
          if (rearb) begin
            if (!found) begin
              state     <= ST_HANDOVER;
              hgrant    <= onehot(DEF_IDX);
              grant_idx <= DEF_IDX;
              to_park   <= 1'b1;
            end else if (winner != hmaster) begin
              state     <= ST_HANDOVER;
              hgrant    <= onehot(winner);
              grant_idx <= winner;
              to_park   <= 1'b0;
            end else begin
              hold_cnt <= '0;
            end
          end else if (!hold_hit) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= ST_PARK;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_ahb_arbiter.sv
module tb_ahb_arbiter;

  localparam int NM   = 4;
  localparam int DEF  = 0;
  localparam int MAXH = 4;

  logic          hclk = 1'b0;
  logic          hreset;
  logic [NM-1:0] hbusreq;
  logic [NM-1:0] hlock;
  logic [1:0]    htrans;
  logic          hready;
  logic [NM-1:0] hgrant;
  logic [2:0]    hmaster;
  logic          hmastlock;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  ahb_arbiter #(.NUM_MASTERS(NM), .DEFAULT_MASTER(DEF), .MAX_HOLD(MAXH)) dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hready(hready), .hgrant(hgrant), .hmaster(hmaster),
    .hmastlock(hmastlock), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 hclk = ~hclk;

  // ---------------- reference model ----------------
  // Bus view: who is granted, who owns the address phase, which master was
  // last served, and how many ready cycles the owner has had so far.
  int m_phase;     // 0: parked, 1: owner busy, 2: grant issued, waiting
  int m_owner, m_granted, m_last, m_tenure;
  bit m_going_park, m_lock;

  function automatic bit locked_m(input int i);
    return hlock[i] && hbusreq[i];
  endfunction

  function automatic int next_in_line(input int last_served);
    for (int k = 1; k <= NM; k++) begin
      int c;
      c = (last_served + k) % NM;
      if (hbusreq[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    int others;
    if (hreset) begin
      m_phase = 0; m_owner = DEF; m_granted = DEF; m_last = DEF;
      m_tenure = 0; m_going_park = 0; m_lock = 0;
      return;
    end
    if (!hready) return;
    w = next_in_line(m_last);
    if (m_phase == 0) begin
      if (w == DEF) begin
        m_phase = 1; m_last = DEF; m_tenure = 0; m_lock = locked_m(DEF);
      end else if (w >= 0) begin
        m_phase = 2; m_granted = w; m_going_park = 0;
      end
    end else if (m_phase == 2) begin
      m_owner = m_granted; m_tenure = 0;
      if (m_going_park) begin
        m_phase = 0; m_lock = 0;
      end else begin
        m_phase = 1; m_last = m_granted; m_lock = locked_m(m_granted);
      end
    end else begin
      others = 0;
      for (int i = 0; i < NM; i++) if (i != m_owner && hbusreq[i]) others++;
      m_lock = locked_m(m_owner);
      if ((htrans == 2'b00 || htrans == 2'b10) && !locked_m(m_owner) &&
          (!hbusreq[m_owner] || (m_tenure >= MAXH && others > 0))) begin
        if (w < 0) begin
          m_phase = 2; m_granted = DEF; m_going_park = 1;
        end else if (w != m_owner) begin
          m_phase = 2; m_granted = w; m_going_park = 0;
        end else begin
          m_tenure = 0;
        end
      end else if (m_tenure < MAXH) begin
        m_tenure++;
      end
    end
  endtask

  always @(posedge hclk) model_step();

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [NM-1:0] eg;
    eg = '0;
    eg[m_granted] = 1'b1;
    chk("model_hgrant", int'(hgrant), int'(eg));
    chk("model_hmaster", int'(hmaster), m_owner);
    chk("model_hmastlock", int'(hmastlock), int'(m_lock));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
    if (chk_en) compare_model();
  endtask

  task automatic drive(input logic [NM-1:0] req, input logic [NM-1:0] lk,
                       input logic [1:0] tr, input logic rdy);
    hbusreq = req; hlock = lk; htrans = tr; hready = rdy;
  endtask

  task automatic lit(input string name, input logic [NM-1:0] g, input int m, input bit l);
    chk({name, "_grant"}, int'(hgrant), int'(g));
    chk({name, "_master"}, int'(hmaster), m);
    chk({name, "_lock"}, int'(hmastlock), int'(l));
  endtask

  initial begin
    hreset = 1'b1;
    drive(4'b0000, 4'b0000, 2'b00, 1'b1);
    tick();
    chk_en = 1'b1;
    tick();
    lit("reset", 4'b0001, 0, 0);
    hreset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    lit("park", 4'b0001, 0, 0);

    // single request from master 2
    drive(4'b0100, 4'b0000, 2'b10, 1'b1);
    tick(); lit("req2_grant", 4'b0100, 0, 0);
    tick(); lit("req2_own", 4'b0100, 2, 0);
    tick();
    drive(4'b0000, 4'b0000, 2'b00, 1'b1);
    tick(); lit("rel2_grant", 4'b0001, 2, 0);
    tick(); lit("rel2_park", 4'b0001, 0, 0);

    // bring the pointer to 0: default master takes the bus directly
    drive(4'b0001, 4'b0000, 2'b10, 1'b1);
    tick(); lit("def_direct", 4'b0001, 0, 0);
    drive(4'b0000, 4'b0000, 2'b00, 1'b1);
    tick(); tick();

    // fairness: 1 and 3 together, 1 wins
    drive(4'b1010, 4'b0000, 2'b11, 1'b1);
    tick(); lit("rr_first", 4'b0010, 0, 0);
    tick(); lit("rr_own1", 4'b0010, 1, 0);
    tick(); tick();
    drive(4'b1000, 4'b0000, 2'b00, 1'b1);
    tick(); lit("rr_second", 4'b1000, 1, 0);
    drive(4'b1010, 4'b0000, 2'b11, 1'b1);
    tick(); lit("rr_own3", 4'b1000, 3, 0);
    for (int i = 0; i < 3; i++) tick();
    lit("rr_wait1", 4'b1000, 3, 0);
    drive(4'b0010, 4'b0000, 2'b00, 1'b1);
    tick(); lit("rr_back1", 4'b0010, 3, 0);
    tick(); lit("rr_own1b", 4'b0010, 1, 0);

    // hold limit with burst protection
    drive(4'b0110, 4'b0000, 2'b11, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(); lit("hold_seq", 4'b0010, 1, 0);
    end
    htrans = 2'b10;
    tick(); lit("hold_move", 4'b0100, 1, 0);
    tick(); lit("hold_own2", 4'b0100, 2, 0);

    // lock and wait states
    drive(4'b0001, 4'b0001, 2'b00, 1'b1);
    tick(); lit("lk_grant", 4'b0001, 2, 0);
    tick(); lit("lk_own", 4'b0001, 0, 1);
    hbusreq = 4'b1001;
    for (int i = 0; i < 20; i++) begin
      htrans = 2'($urandom_range(0, 3));
      tick(); lit("lk_hold", 4'b0001, 0, 1);
    end
    drive(4'b1001, 4'b0000, 2'b10, 1'b1);
    tick(); lit("unlk_grant", 4'b1000, 0, 0);
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); lit("unlk_wait", 4'b1000, 0, 0);
    end
    hready = 1'b1;
    tick(); lit("unlk_own3", 4'b1000, 3, 0);

    // reset in the middle of a handover
    drive(4'b0100, 4'b0000, 2'b00, 1'b1);
    tick(); lit("mid_ho", 4'b0100, 3, 0);
    hreset = 1'b1;
    tick(); lit("mid_reset", 4'b0001, 0, 0);
    hreset = 1'b0;
    drive(4'b0011, 4'b0000, 2'b00, 1'b1);
    tick(); lit("ptr_restored", 4'b0010, 0, 0);
    tick(); lit("ptr_own1", 4'b0010, 1, 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [NM-1:0] r, l;
      r = hbusreq;
      l = hlock;
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
        if ($urandom_range(0, 5) == 0) l[i] = ~l[i];
      end
      drive(r, l & r, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
      hreset = ($urandom_range(0, 599) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
